// File: rtl/rx_mon_pkg.sv
// Shared types and helpers for the RX PRBS monitor.
// FSM encodings, PRBS taps (15,14,12,3), next-word and popcount helpers.
package rx_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SEED      = 3'd2,
    ST_CHECK     = 3'd3
  } mon_state_t;

  localparam int TAP_A = 15;
  localparam int TAP_B = 14;
  localparam int TAP_C = 12;
  localparam int TAP_D = 3;

  function automatic logic [15:0] prbs_next(
    input logic [15:0] d
  );
    return {d[14:0], d[TAP_A] ^ d[TAP_B] ^ d[TAP_C] ^ d[TAP_D]};
  endfunction

  function automatic logic [4:0] popcnt16(
    input logic [15:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// The add is done one bit wider than the widest operand so it cannot wrap.
module sat_cnt #(
  parameter int W  = 32,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [IW-1:0] inc_val,
  output logic [W-1:0]  cnt
);

  localparam int SW = ((W > IW) ? W : IW) + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] top;

  assign sum = SW'(cnt) + SW'(inc_val);
  assign top = SW'({W{1'b1}});

  // clear beats increment; otherwise add and clamp at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sum > top) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/rx_prbs_mon.sv
// PRBS error monitor behind the bitslip aligner.
// Define RX_PRBS_MON_BITCNT_EN to build the errored-bit counter.
module rx_prbs_mon #(
  parameter int CNT_W         = 32,
  parameter int RESYNC_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      rx_align_data,
  input  logic             rx_align_locked,
  input  logic             clear,
  input  logic             snap_req,
  output logic [CNT_W-1:0] snap_word_cnt,
  output logic [CNT_W-1:0] snap_err_word_cnt,
  output logic [CNT_W-1:0] snap_err_bit_cnt,
  output logic [15:0]      snap_resync_cnt,
  output logic [15:0]      snap_lock_loss_cnt,
  output logic             snap_valid,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [2:0]       mon_state
);

  import rx_mon_pkg::*;

  localparam int RW = $clog2(RESYNC_THRESH + 1);

  mon_state_t       state_q;
  mon_state_t       state_d;
  logic [15:0]      d_q;
  logic [15:0]      d_prev;
  logic [15:0]      exp_word;
  logic [RW-1:0]    run_cnt;
  logic             in_check;
  logic             in_seed;
  logic             mismatch;
  logic             lock_lost;
  logic             resync_hit;
  logic             resync_inc;
  logic             lock_inc;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_word_cnt;
  logic [15:0]      resync_cnt;
  logic [15:0]      lock_loss_cnt;

  assign exp_word   = prbs_next(d_prev);
  assign mismatch   = in_check && (d_q != exp_word);
  assign lock_lost  = (in_check || in_seed) && !rx_align_locked;
  assign resync_hit = mismatch &&
                      (run_cnt == RW'(RESYNC_THRESH - 1));
  assign lock_inc   = en && lock_lost;
  assign resync_inc = en && !lock_lost && resync_hit;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: en low wins, then lock loss, then resync
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (rx_align_locked) state_d = ST_SEED;
      ST_SEED:      state_d = ST_CHECK;
      ST_CHECK:     if (resync_hit) state_d = ST_SEED;
      default:      state_d = ST_IDLE;
    endcase
    if (lock_lost) state_d = ST_WAIT_LOCK;
    if (!en) state_d = ST_IDLE;
  end

  // state decode outputs
  always_comb begin
    mon_state = state_q;
    in_check  = (state_q == ST_CHECK);
    in_seed   = (state_q == ST_SEED);
  end

  // data pipeline, error run length and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q        <= '0;
      d_prev     <= '0;
      run_cnt    <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      d_q        <= rx_align_data;
      d_prev     <= d_q;
      err_pulse  <= mismatch;
      err_sticky <= clear ? 1'b0 : (err_sticky | mismatch);
      if (!mismatch || resync_hit) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + RW'(1);
      end
    end
  end

  sat_cnt #(.W(CNT_W), .IW(1)) u_word_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc_val(in_check), .cnt(word_cnt)
  );

  sat_cnt #(.W(CNT_W), .IW(1)) u_err_word_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc_val(mismatch), .cnt(err_word_cnt)
  );

  sat_cnt #(.W(16), .IW(1)) u_resync_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc_val(resync_inc), .cnt(resync_cnt)
  );

  sat_cnt #(.W(16), .IW(1)) u_lock_loss_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc_val(lock_inc), .cnt(lock_loss_cnt)
  );

`ifdef RX_PRBS_MON_BITCNT_EN
  logic [4:0]       bit_inc;
  logic [CNT_W-1:0] err_bit_cnt;

  assign bit_inc = in_check ? popcnt16(d_q ^ exp_word) : 5'd0;

  sat_cnt #(.W(CNT_W), .IW(5)) u_err_bit_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc_val(bit_inc), .cnt(err_bit_cnt)
  );

  // bit-count snapshot register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_err_bit_cnt <= '0;
    end else if (snap_req) begin
      snap_err_bit_cnt <= err_bit_cnt;
    end
  end
`else
  assign snap_err_bit_cnt = '0;
`endif

  // snapshot sees pre-clear values since both sample the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_valid         <= 1'b0;
      snap_word_cnt      <= '0;
      snap_err_word_cnt  <= '0;
      snap_resync_cnt    <= '0;
      snap_lock_loss_cnt <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_word_cnt      <= word_cnt;
        snap_err_word_cnt  <= err_word_cnt;
        snap_resync_cnt    <= resync_cnt;
        snap_lock_loss_cnt <= lock_loss_cnt;
      end
    end
  end

endmodule

// File: tb/tb_rx_prbs_mon.sv
// Self-checking bench for rx_prbs_mon.
// Second instance with CNT_W=4 covers counter saturation.
`timescale 1ns/1ps
module tb_rx_prbs_mon;

`ifdef RX_PRBS_MON_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        locked = 1'b0;
  logic        clear = 1'b0;
  logic        snap_req = 1'b0;
  logic [15:0] data = '0;

  logic [31:0] s_word, s_eword, s_ebit;
  logic [15:0] s_rs, s_ll;
  logic        s_valid, err_pulse, err_sticky;
  logic [2:0]  mon_state;

  logic [3:0]  q_word, q_eword, q_ebit;
  logic [15:0] q_rs, q_ll;
  logic        q_valid, q_pulse, q_sticky;
  logic [2:0]  q_state;

  always #5 clk = ~clk;

  rx_prbs_mon u_dut (
    .clk(clk), .rst(rst), .en(en),
    .rx_align_data(data), .rx_align_locked(locked),
    .clear(clear), .snap_req(snap_req),
    .snap_word_cnt(s_word), .snap_err_word_cnt(s_eword),
    .snap_err_bit_cnt(s_ebit), .snap_resync_cnt(s_rs),
    .snap_lock_loss_cnt(s_ll), .snap_valid(s_valid),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .mon_state(mon_state)
  );

  rx_prbs_mon #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en),
    .rx_align_data(data), .rx_align_locked(locked),
    .clear(clear), .snap_req(snap_req),
    .snap_word_cnt(q_word), .snap_err_word_cnt(q_eword),
    .snap_err_bit_cnt(q_ebit), .snap_resync_cnt(q_rs),
    .snap_lock_loss_cnt(q_ll), .snap_valid(q_valid),
    .err_pulse(q_pulse), .err_sticky(q_sticky),
    .mon_state(q_state)
  );

  typedef struct {
    logic [63:0] w, ew, eb, rs, ll;
  } snap_t;

  typedef struct {
    logic [63:0] name;
    int          n, first, stride, nflip;
    logic [15:0] mask;
    int          errs;
    bit          coinc, sat;
  } vec_t;

  snap_t       sb[$];
  vec_t        vt[5];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] lfsr = 16'hACE1;
  logic [15:0] last_w = '0;

  function automatic logic [15:0] tb_next(input logic [15:0] w);
    return {w[14:0], w[15] ^ w[14] ^ w[12] ^ w[3]};
  endfunction

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  function automatic vec_t mk(
    input logic [63:0] nm, input int n, first, stride, nflip,
    input logic [15:0] mask, input int errs,
    input bit coinc, sat
  );
    vec_t v;
    v.name = nm; v.n = n; v.first = first;
    v.stride = stride; v.nflip = nflip; v.mask = mask;
    v.errs = errs; v.coinc = coinc; v.sat = sat;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic present(input logic [15:0] w);
    data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    last_w = lfsr;
    lfsr = tb_next(lfsr);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic arm();
    en = 1'b1;
    locked = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arm_state", mon_state, 1);
  endtask

  task automatic run_words(
    input int n, first, stride, nflip,
    input logic [15:0] mask, input bit do_stop, chk_pulse,
    output int bits
  );
    logic [15:0] w;
    logic [15:0] prev;
    bit          mm;
    bit          mm_prev;
    bits = 0;
    mm_prev = 1'b0;
    prev = '0;
    locked = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = lfsr;
      for (int k = 0; k < nflip; k++)
        if (i == first + k * stride) w = w ^ mask;
      adv();
      mm = (i > 0) && (w != tb_next(prev));
      if (mm) bits += $countones(w ^ tb_next(prev));
      present(w);
      if (chk_pulse)
        chk($sformatf("err_pulse[%0d]", i), err_pulse, mm_prev);
      mm_prev = mm;
      prev = w;
    end
    if (do_stop) begin
      en = 1'b0;
      @(posedge clk);
      #1;
      if (chk_pulse) chk("err_pulse_last", err_pulse, mm_prev);
    end
  endtask

  task automatic snap(
    input logic [63:0] w, ew, eb, rs, ll, input bit with_clear
  );
    snap_t e;
    bit    seen;
    e.w = w; e.ew = ew; e.eb = eb; e.rs = rs; e.ll = ll;
    sb.push_back(e);
    snap_req = 1'b1;
    clear = with_clear;
    @(posedge clk);
    #1;
    snap_req = 1'b0;
    clear = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      if (s_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("snap_word_cnt", s_word, e.w);
        chk("snap_err_word_cnt", s_eword, e.ew);
        chk("snap_err_bit_cnt", s_ebit, e.eb);
        chk("snap_resync_cnt", s_rs, e.rs);
        chk("snap_lock_loss_cnt", s_ll, e.ll);
        chk("snap_valid_at_t", t, 0);
        @(posedge clk);
        #1;
        chk("snap_valid_one_cycle", s_valid, 0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL snap_timeout: no snap_valid, required within 4 cycles");
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          bits;
    int          gbits;
    logic [15:0] g [4];
    logic [15:0] p;
    vec_t        v;

    vt[0] = mk("clean", 1000, 0, 0, 0, 16'h0000, 0, 0, 0);
    vt[1] = mk("bit5", 200, 100, 0, 1, 16'h0020, 2, 0, 0);
    vt[2] = mk("taps", 100, 50, 0, 1, 16'h0009, 2, 0, 0);
    vt[3] = mk("sat", 300, 10, 20, 10, 16'h8000, 20, 0, 1);
    vt[4] = mk("coinc", 40, 9, 10, 4, 16'h0020, 7, 1, 0);

    #1;
    chk("rst_mon_state", mon_state, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_snap_valid", s_valid, 0);
    chk("rst_snap_word", s_word, 0);
    chk("rst_snap_eword", s_eword, 0);
    chk("rst_snap_ebit", s_ebit, 0);
    chk("rst_snap_rs", s_rs, 0);
    chk("rst_snap_ll", s_ll, 0);
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int j = 0; j < 5; j++) begin
      v = vt[j];
      pulse_clear();
      arm();
      run_words(v.n, v.first, v.stride, v.nflip, v.mask,
                1'b1, 1'b1, bits);
      chk($sformatf("%0s_sticky", v.name), err_sticky, v.errs > 0);
      if (v.coinc) begin
        snap(v.n - 1, v.errs, BITCNT ? bits : 0, 0, 0, 1'b1);
        chk("coinc_sticky_cleared", err_sticky, 0);
        snap(0, 0, 0, 0, 0, 1'b0);
      end else begin
        snap(v.n - 1, v.errs, BITCNT ? bits : 0, 0, 0, 1'b0);
      end
      if (v.sat) begin
        chk("sat4_word", q_word, sat4(v.n - 1));
        chk("sat4_eword", q_eword, sat4(v.errs));
        chk("sat4_ebit", q_ebit, BITCNT ? sat4(bits) : 0);
        chk("sat4_rs", q_rs, 0);
        // reset in the middle of CHECK
        arm();
        run_words(20, 0, 0, 0, 16'h0, 1'b0, 1'b0, bits);
        chk("pre_rst_state", mon_state, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", mon_state, 0);
        chk("mid_rst_sticky", err_sticky, 0);
        chk("mid_rst_pulse", err_pulse, 0);
        chk("mid_rst_snap_word", s_word, 0);
        chk("mid_rst_snap_eword", s_eword, 0);
        chk("mid_rst_q_eword", q_eword, 0);
        chk("mid_rst_q_sticky", q_sticky, 0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          present(lfsr);
          adv();
          chk($sformatf("rearm_state[%0d]", k), mon_state, k + 1);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
      end
    end

    // burst of four garbage words forces a resync
    g[0] = 16'hDEAD; g[1] = 16'hBEEF;
    g[2] = 16'h1234; g[3] = 16'h5678;
    pulse_clear();
    arm();
    run_words(50, 0, 0, 0, 16'h0, 1'b0, 1'b0, bits);
    p = last_w;
    gbits = 0;
    for (int k = 0; k < 4; k++) begin
      gbits += $countones(g[k] ^ tb_next(p));
      present(g[k]);
      p = g[k];
    end
    present(lfsr);
    adv();
    chk("burst_seed_state", mon_state, 2);
    chk("burst_pulse_4th", err_pulse, 1);
    present(lfsr);
    adv();
    chk("burst_check_state", mon_state, 3);
    chk("burst_pulse_seed", err_pulse, 0);
    run_words(48, 0, 0, 0, 16'h0, 1'b1, 1'b1, bits);
    snap(102, 4, BITCNT ? gbits : 0, 1, 0, 1'b0);

    // lock drop for three cycles during CHECK
    pulse_clear();
    arm();
    run_words(30, 0, 0, 0, 16'h0, 1'b0, 1'b0, bits);
    locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      present(lfsr);
      adv();
      chk($sformatf("lock_drop_state[%0d]", k), mon_state, 1);
    end
    locked = 1'b1;
    present(lfsr);
    adv();
    chk("relock_seed_state", mon_state, 2);
    present(lfsr);
    adv();
    chk("relock_check_state", mon_state, 3);
    run_words(28, 0, 0, 0, 16'h0, 1'b1, 1'b1, bits);
    chk("lock_sticky", err_sticky, 0);
    snap(58, 0, 0, 0, 1, 1'b0);

    // clear on a counting edge wins over the increment
    pulse_clear();
    arm();
    run_words(10, 0, 0, 0, 16'h0, 1'b0, 1'b0, bits);
    clear = 1'b1;
    present(lfsr);
    adv();
    clear = 1'b0;
    run_words(10, 0, 0, 0, 16'h0, 1'b1, 1'b0, bits);
    snap(11, 0, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_prbs_mon.md
RX_PRBS_MON -- requirements
Module: rx_prbs_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of word, error-word and error-bit counters.
REQ-002 SHALL have parameter RESYNC_THRESH, default 4: number of consecutive errored words in CHECK that forces a re-seed.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: monitor enable; low forces IDLE.
REQ-006 SHALL have port rx_align_data, input, 16: bit-aligned raw RX word from the bitslip aligner.
REQ-007 SHALL have port rx_align_locked, input, 1: aligner lock indication.
REQ-008 SHALL have port clear, input, 1: single-cycle pulse that zeroes all live counters.
REQ-009 SHALL have port snap_req, input, 1: single-cycle pulse requesting a counter snapshot.
REQ-010 SHALL have outputs snap_word_cnt, snap_err_word_cnt and snap_err_bit_cnt, each CNT_W wide: snapshot values.
REQ-011 SHALL have outputs snap_resync_cnt and snap_lock_loss_cnt, each 16 wide: snapshot values.
REQ-012 SHALL have output snap_valid, 1: one-cycle strobe indicating the snapshot outputs were updated.
REQ-013 SHALL have outputs err_pulse, 1 (errored word detected) and err_sticky, 1 (set on any err_pulse, cleared only by clear or reset).
REQ-014 SHALL have output mon_state, 3: current FSM state encoding.

Function
REQ-015 SHALL register rx_align_data into d_q each cycle; expected word exp = {d_prev[14:0], d_prev[15]^d_prev[14]^d_prev[12]^d_prev[3]}, where d_prev is the prior d_q.
REQ-016 SHALL implement FSM states IDLE=0, WAIT_LOCK=1, SEED=2, CHECK=3.
REQ-017 SHALL move from any state to IDLE when en=0, and from IDLE to WAIT_LOCK when en=1.
REQ-018 SHALL move from WAIT_LOCK to SEED when rx_align_locked=1.
REQ-019 SHALL spend exactly one cycle in SEED, loading d_prev from d_q without comparison, then enter CHECK.
REQ-020 SHALL, in CHECK, compare d_q against exp every cycle; word_cnt increments on every compared word.
REQ-021 SHALL, on a mismatch, assert err_pulse and increment err_word_cnt; err_bit_cnt increases by popcount(d_q XOR exp), 0..16.
REQ-022 SHALL, after RESYNC_THRESH consecutive mismatches, return to SEED and increment resync_cnt.
REQ-023 SHALL, on rx_align_locked falling while in CHECK or SEED, go to WAIT_LOCK and increment lock_loss_cnt; lock loss takes priority over resync.
REQ-024 SHALL assert err_pulse exactly 2 clk after the errored word is presented on rx_align_data; counters SHALL update in the same cycle as err_pulse.
REQ-025 SHALL saturate every counter at all-ones, never wrap, and never let a multi-bit add overflow past saturation.
REQ-026 SHALL load all snap_* outputs from the live counters on the cycle after snap_req and assert snap_valid for that one cycle.
REQ-027 SHALL, when clear is asserted, zero live counters and err_sticky on the next cycle; if clear and snap_req coincide, the snapshot SHALL capture pre-clear values.
REQ-028 SHALL let clear override an increment in the same cycle, giving a zero result.
REQ-029 SHALL NOT count or compare in IDLE, WAIT_LOCK or SEED.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state IDLE; all counters, snap_* outputs, snap_valid, err_pulse, err_sticky, d_q and d_prev to 0; mon_state to 0.
REQ-031 SHALL, if rst asserts mid-CHECK, discard partial state; after release it re-enters through WAIT_LOCK and SEED.

Configuration
REQ-032 SHALL, when macro RX_PRBS_MON_BITCNT_EN is defined, include the popcount logic and the err_bit_cnt counter.
REQ-033 SHALL, when RX_PRBS_MON_BITCNT_EN is undefined, drive err_bit_cnt and snap_err_bit_cnt to constant 0 with no popcount logic; all other behaviour is unchanged.

Structure
REQ-034 SHALL place the state encodings, the PRBS tap constants (15,14,12,3) and a 16-bit next-word function in shared package rx_mon_pkg.
REQ-035 SHALL implement the saturating counter as sub-module sat_cnt (parameter W; inputs inc_val, clr), instantiated once per counter.

Verification
REQ-036 SHALL test clean case: en=1, locked=1, 1000 valid words -> word_cnt=999 (SEED word not counted), err_word_cnt=0, err_sticky=0.
REQ-037 SHALL test single fault: flip bit 5 of one word -> err_pulse 2 clk later, err_word_cnt=2 (corrupt word plus its successor check), err_bit_cnt in the 2-4 range as computed by the bench model, no resync.
REQ-038 SHALL test burst: 4 consecutive garbage words -> resync_cnt=1, SEED then CHECK, counting resumes with no further errors.
REQ-039 SHALL test lock drop: drop locked for 3 cycles during CHECK -> lock_loss_cnt=1, mon_state=1 then 2 then 3 on relock.
REQ-040 SHALL test coincident events: snap_req and clear in the same cycle with err_word_cnt=7 -> snap_err_word_cnt=7, live count=0, snap_valid high for 1 cycle.
REQ-041 SHALL test saturation: preload via CNT_W=4 build and 20 errors -> err_word_cnt=15; rst mid-CHECK -> all outputs 0 immediately.
